noc_vc_input_buffer: RTL and testbench
======================================

// Module: noc_vc_input_buffer
// PURPOSE
//  Per-virtual-channel flit FIFO sitting directly downstream of one VC arbitration sender
//  channel (one instance per channel).
//  Stores flits with header/tail tags and drains them to the route/switch stage.
//  Generates VCready: it tells the arbiter whether a new packet may be steered here.
// PARAMETERS
//  DEPTH            8   flit entries; power of 2, >=2
//  VC_READY_THRESH  4   free entries required (with no open packet) to assert VCready; 1..DEPTH
//  Flit width is `Noc_Data_Width, taken from Noc_parameters.v.
// PORTS
//  noc_clk                 in   1    clock; one clock domain
//  noc_rst_n               in   1    asynchronous, active-low reset
//  Noc_receive_valid       in   1    upstream flit valid
//  Noc_receive_ready       out  1    buffer can accept a flit
//  Noc_receive_flit        in   W    upstream flit; W = `Noc_Data_Width
//  Noc_receive_is_header   in   1    flit is packet header
//  Noc_receive_is_tail     in   1    flit is packet tail
//  Noc_VCready             out  1    VC may be granted a new packet
//  Noc_send_valid          out  1    head flit valid
//  Noc_send_ready          in   1    downstream accepts head flit
//  Noc_send_flit           out  W    head flit
//  Noc_send_is_header      out  1    head flit header tag
//  Noc_send_is_tail        out  1    head flit tail tag
//  Noc_pkt_pending         out  1    at least one complete packet (tail stored) in buffer
// BEHAVIOUR
//  - Clock/reset: single clock noc_clk; noc_rst_n is asynchronous, active-low.
//  - Handshakes:
//    - Write when Noc_receive_valid && Noc_receive_ready.
//    - Read when Noc_send_valid && Noc_send_ready.
//  - Storage:
//    - Entries hold {tail, header, flit}.
//    - Pointers wr_ptr/rd_ptr wrap modulo DEPTH.
//    - count is $clog2(DEPTH)+1 bits.
//  - Flags: Noc_receive_ready = (count != DEPTH); Noc_send_valid = (count != 0).
//    - No pass-through when full: a read in the full cycle frees the slot for the next cycle only.
//  - Send outputs: show-ahead. Noc_send_* = mem[rd_ptr].
//    - Write-to-Noc_send_valid latency is 1 cycle.
//  - Simultaneous read+write (not full, not empty): count unchanged, both pointers advance.
//  - Packet FSM (write side), states IDLE and IN_PKT:
//    - IDLE   -> IN_PKT on accepted header with !tail.
//    - IN_PKT -> IDLE on accepted tail.
//    - A header+tail (single-flit) packet stays in IDLE.
//  - Noc_VCready = (state==IDLE) && (DEPTH-count >= VC_READY_THRESH).
//    - Decoded from registers only; no input-to-output combinational path.
//  - pkt_cnt ($clog2(DEPTH)+1 bits): +1 on accepted tail write, -1 on accepted tail read.
//    - Both in the same cycle: unchanged.
//    - Noc_pkt_pending = (pkt_cnt != 0).
//  - Protocol violations (header while IN_PKT, non-header flit while IDLE):
//    - The flit is still stored.
//    - FSM follows the rules above: a header re-enters IN_PKT; a tail returns to IDLE.
//  - Reset values: Noc_receive_ready=1, Noc_VCready=1, Noc_send_valid=0,
//    Noc_send_flit/is_header/is_tail=0, Noc_pkt_pending=0, state=IDLE.
//    - Memory contents are don't-care; send outputs are gated to 0 while empty.
//  - Reset mid-packet: all stored flits are discarded; state returns to IDLE.
// CONFIGURATION
//  - Macro NOC_VC_BUF_STATS_EN.
//  - When defined, adds these ports:
//    - Noc_proto_err  out  1   sticky; set on any protocol violation; cleared only by reset.
//    - Noc_pkt_total  out  16  accepted-tail counter; wraps 0xFFFF->0; reset 0.
//  - When undefined: those ports and their registers are absent; other behaviour is identical.
// TESTING
//  1. Reset, idle -> Noc_receive_ready=1, Noc_VCready=1, Noc_send_valid=0, Noc_pkt_pending=0.
//  2. 3-flit packet (H,B,T) = 0xA1,0xA2,0xA3 with Noc_send_ready=0:
//     - Noc_VCready=0 from the cycle after the header until the cycle after the tail.
//     - Noc_VCready=1 after the tail (free=5 >= 4); Noc_pkt_pending=1.
//     - Then Noc_send_ready=1 -> flits exit in order, with tags intact.
//  3. Fill 8 flits, out_ready=0:
//     - Noc_receive_ready=0 at count 8; further valid is not accepted.
//     - One read -> Noc_receive_ready=1 on the next cycle; pointer wrap verified.
//  4. Continuous write+read at full rate for 20 single-flit packets:
//     - count stays 1; zero loss; pkt_cnt never exceeds 1.
//  5. Async reset asserted mid-packet (2 of 4 flits written) -> all outputs return to reset values.
//     - A subsequent clean packet passes.
//  6. NOC_VC_BUF_STATS_EN defined, body flit sent in IDLE:
//     - Noc_proto_err=1 and stays 1.
//     - Noc_pkt_total increments once per tail.

Source files
------------

// File: rtl/noc_vc_input_buffer.sv
// Per-VC flit FIFO with packet tracking and VCready generation for the VC arbiter.
// Optional statistics (sticky protocol-error flag, accepted-tail counter) under NOC_VC_BUF_STATS_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_vc_input_buffer #(
  parameter int DEPTH           = 8,
  parameter int VC_READY_THRESH = 4
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       Noc_receive_valid,
  output logic                       Noc_receive_ready,
  input  logic [`Noc_Data_Width-1:0] Noc_receive_flit,
  input  logic                       Noc_receive_is_header,
  input  logic                       Noc_receive_is_tail,
  output logic                       Noc_VCready,
  output logic                       Noc_send_valid,
  input  logic                       Noc_send_ready,
  output logic [`Noc_Data_Width-1:0] Noc_send_flit,
  output logic                       Noc_send_is_header,
  output logic                       Noc_send_is_tail,
`ifdef NOC_VC_BUF_STATS_EN
  output logic                       Noc_proto_err,
  output logic [15:0]                Noc_pkt_total,
`endif
  output logic                       Noc_pkt_pending
);

  localparam int W  = `Noc_Data_Width;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH   = CW'(VC_READY_THRESH);

  typedef enum logic {IDLE, IN_PKT} pkt_state_e;

  typedef struct packed {
    logic         tail;
    logic         header;
    logic [W-1:0] flit;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, pkt_cnt_q, pkt_cnt_d;
  pkt_state_e      state_q, state_d;
  logic            wr_en, rd_en, wr_tail, rd_tail;

  assign Noc_receive_ready = (count_q != FULL_CNT);
  assign Noc_send_valid    = (count_q != '0);
  assign wr_en             = Noc_receive_valid && Noc_receive_ready;
  assign rd_en             = Noc_send_valid && Noc_send_ready;

  // Show-ahead head entry, forced to zero while empty since memory is never cleared.
  assign head               = Noc_send_valid ? mem_q[rd_ptr_q] : '0;
  assign Noc_send_flit      = head.flit;
  assign Noc_send_is_header = head.header;
  assign Noc_send_is_tail   = head.tail;

  assign wr_tail = wr_en && Noc_receive_is_tail;
  assign rd_tail = rd_en && head.tail;

  assign Noc_VCready     = (state_q == IDLE) && ((FULL_CNT - count_q) >= THRESH);
  assign Noc_pkt_pending = (pkt_cnt_q != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;
    state_d   = state_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case ({wr_tail, rd_tail})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // Tail wins over header, so single-flit packets and stray tails both land in IDLE.
    if (wr_en) begin
      if (Noc_receive_is_tail)        state_d = IDLE;
      else if (Noc_receive_is_header) state_d = IN_PKT;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      state_q   <= state_d;
    end
  end

  // NOTE: storage has no reset; count_q alone decides validity, keeping the array plain RAM.
  always_ff @(posedge noc_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{tail: Noc_receive_is_tail,
                                    header: Noc_receive_is_header,
                                    flit: Noc_receive_flit};
  end

`ifdef NOC_VC_BUF_STATS_EN
  logic        proto_err_q, proto_err_d;
  logic [15:0] pkt_total_q, pkt_total_d;
  logic        violation;

  assign violation = wr_en && ((state_q == IN_PKT &&  Noc_receive_is_header) ||
                               (state_q == IDLE   && !Noc_receive_is_header));
  assign proto_err_d = proto_err_q | violation;
  assign pkt_total_d = wr_tail ? pkt_total_q + 16'd1 : pkt_total_q;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      proto_err_q <= 1'b0;
      pkt_total_q <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      pkt_total_q <= pkt_total_d;
    end
  end

  assign Noc_proto_err = proto_err_q;
  assign Noc_pkt_total = pkt_total_q;
`endif

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer: inputs change and outputs are sampled on the falling edge.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_vc_input_buffer;

  localparam int W = `Noc_Data_Width;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid, rx_ready, rx_hdr, rx_tail;
  logic [W-1:0] rx_flit;
  logic         vc_ready;
  logic         tx_valid, tx_ready, tx_hdr, tx_tail;
  logic [W-1:0] tx_flit;
  logic         pkt_pending;
`ifdef NOC_VC_BUF_STATS_EN
  logic         proto_err;
  logic [15:0]  pkt_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  noc_vc_input_buffer #(.DEPTH(8), .VC_READY_THRESH(4)) dut (
    .noc_clk               (clk),
    .noc_rst_n             (rst_n),
    .Noc_receive_valid     (rx_valid),
    .Noc_receive_ready     (rx_ready),
    .Noc_receive_flit      (rx_flit),
    .Noc_receive_is_header (rx_hdr),
    .Noc_receive_is_tail   (rx_tail),
    .Noc_VCready           (vc_ready),
    .Noc_send_valid        (tx_valid),
    .Noc_send_ready        (tx_ready),
    .Noc_send_flit         (tx_flit),
    .Noc_send_is_header    (tx_hdr),
    .Noc_send_is_tail      (tx_tail),
`ifdef NOC_VC_BUF_STATS_EN
    .Noc_proto_err         (proto_err),
    .Noc_pkt_total         (pkt_total),
`endif
    .Noc_pkt_pending       (pkt_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] f, input logic h, input logic t);
    rx_valid = v;
    rx_flit  = f;
    rx_hdr   = h;
    rx_tail  = t;
  endtask

  task automatic check_head(input string tag, input logic [W-1:0] f, input logic h, input logic t);
    check({tag, ".valid"}, 32'(tx_valid), 32'd1);
    check({tag, ".flit"},  32'(tx_flit),  32'(f));
    check({tag, ".hdr"},   32'(tx_hdr),   32'(h));
    check({tag, ".tail"},  32'(tx_tail),  32'(t));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".rx_ready"}, 32'(rx_ready),    32'd1);
    check({tag, ".vc_ready"}, 32'(vc_ready),    32'd1);
    check({tag, ".tx_valid"}, 32'(tx_valid),    32'd0);
    check({tag, ".tx_flit"},  32'(tx_flit),     32'd0);
    check({tag, ".tx_tags"},  32'({tx_hdr, tx_tail}), 32'd0);
    check({tag, ".pending"},  32'(pkt_pending), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // 1: reset state
    check_idle("reset");

    // 2: three-flit packet held, then drained
    drive(1'b1, 'hA1, 1'b1, 1'b0);
    @(negedge clk);
    check("pkt.vc_after_hdr", 32'(vc_ready), 32'd0);
    check_head("pkt.head_lat1", 'hA1, 1'b1, 1'b0);
    drive(1'b1, 'hA2, 1'b0, 1'b0);
    @(negedge clk);
    check("pkt.vc_after_body", 32'(vc_ready), 32'd0);
    check("pkt.pend_open", 32'(pkt_pending), 32'd0);
    drive(1'b1, 'hA3, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("pkt.vc_after_tail", 32'(vc_ready), 32'd1);
    check("pkt.pend_closed", 32'(pkt_pending), 32'd1);
    tx_ready = 1'b1;
    check_head("pkt.out0", 'hA1, 1'b1, 1'b0);
    @(negedge clk);
    check_head("pkt.out1", 'hA2, 1'b0, 1'b0);
    @(negedge clk);
    check_head("pkt.out2", 'hA3, 1'b0, 1'b1);
    @(negedge clk);
    tx_ready = 1'b0;
    check_idle("pkt.drained");

    // 3: fill to full, blocked write, single read frees one slot, wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'(32'hB0 + i), 1'b1, 1'b1);
      @(negedge clk);
    end
    drive(1'b1, 'hEE, 1'b1, 1'b1);
    check("full.rx_ready", 32'(rx_ready), 32'd0);
    check("full.vc_ready", 32'(vc_ready), 32'd0);
    check("full.pending", 32'(pkt_pending), 32'd1);
    @(negedge clk);
    check("full.blocked", 32'(rx_ready), 32'd0);
    check_head("full.head", 'hB0, 1'b1, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("full.freed", 32'(rx_ready), 32'd1);
    check_head("full.after_pop", 'hB1, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("full.refilled", 32'(rx_ready), 32'd0);
    tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check_head($sformatf("full.drain%0d", i), W'(32'hB0 + i), 1'b1, 1'b1);
      @(negedge clk);
    end
    check_head("full.wrapped", 'hEE, 1'b1, 1'b1);
    @(negedge clk);
    check_idle("full.empty");

    // 4: back-to-back single-flit packets with continuous draining
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, W'(32'hC0 + i), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("stream%0d.flit", i), 32'(tx_flit), 32'hC0 + i);
      check($sformatf("stream%0d.lvl", i),
            32'({tx_valid, rx_ready, vc_ready, pkt_pending}), 32'b1111);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    tx_ready = 1'b0;
    check_idle("stream.empty");

    // 5: async reset in the middle of a four-flit packet
    drive(1'b1, 'hD1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 'hD2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("mid.vc_ready", 32'(vc_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("mid.reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 'hE1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 'hE2, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    tx_ready = 1'b1;
    check_head("clean.out0", 'hE1, 1'b1, 1'b0);
    @(negedge clk);
    check_head("clean.out1", 'hE2, 1'b0, 1'b1);
    @(negedge clk);
    tx_ready = 1'b0;
    check_idle("clean.empty");

`ifdef NOC_VC_BUF_STATS_EN
    // 6: statistics
    do_reset();
    check("st.err_rst", 32'(proto_err), 32'd0);
    check("st.tot_rst", 32'(pkt_total), 32'd0);
    drive(1'b1, 'hF1, 1'b0, 1'b0);
    @(negedge clk);
    check("st.err_body", 32'(proto_err), 32'd1);
    check("st.tot_body", 32'(pkt_total), 32'd0);
    drive(1'b1, 'hF2, 1'b0, 1'b1);
    @(negedge clk);
    check("st.tot_tail1", 32'(pkt_total), 32'd1);
    drive(1'b1, 'hF3, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("st.tot_tail2", 32'(pkt_total), 32'd2);
    check("st.err_sticky", 32'(proto_err), 32'd1);
    @(negedge clk);
    check("st.err_hold", 32'(proto_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
